// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a start/active/done handshake.
// Latency: a write into an empty idle FIFO in cycle N gives o_tx_dv in cycle N+2.
// Backpressure: writes while full are dropped; optional drop counter under UART_TX_FIFO_OVF_CNT_EN.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [7:0]            i_wr_byte,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_tx_dv,
    output logic [7:0]            o_tx_byte,
    input  logic                  i_tx_active,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_tx_err
`ifdef UART_TX_FIFO_OVF_CNT_EN
    ,
    output logic [7:0]            o_ovf_cnt
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACT,
        WAIT_DONE,
        GAP
    } state_t;

    state_t                 state;
    logic [1:0]             tmo_cnt;
    logic [7:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic                   wr_acc;
    logic                   pop;
    logic [DEPTH_LOG2:0]    cnt_nxt;

    // Accept/pop decisions use only registered flags, so a pop never frees room for a same-cycle write.
    always_comb begin
        wr_acc  = i_wr_en && !o_full;
        pop     = (state == IDLE) && !o_empty;
        cnt_nxt = o_count;
        case ({wr_acc, pop})
            2'b10:   cnt_nxt = o_count + CNT_ONE;
            2'b01:   cnt_nxt = o_count - CNT_ONE;
            default: cnt_nxt = o_count;
        endcase
    end

    // Byte storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= i_wr_byte;
        end
    end

    // Pointers, count and the registered full/empty flags derived from the next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
            o_empty <= 1'b1;
            o_full  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            o_count <= cnt_nxt;
            o_empty <= (cnt_nxt == '0);
            o_full  <= (cnt_nxt == CNT_FULL);
        end
    end

    // Transmit handshake FSM; all outputs registered, o_tx_byte held between pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tmo_cnt   <= 2'd0;
            o_tx_dv   <= 1'b0;
            o_tx_byte <= 8'h00;
            o_tx_err  <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            o_tx_dv  <= 1'b0;
            o_tx_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        o_tx_byte <= mem[rd_ptr];
                        o_tx_dv   <= 1'b1;
                        o_busy    <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    tmo_cnt <= 2'd0;
                    state   <= WAIT_ACT;
                end
                WAIT_ACT: begin
                    if (i_tx_active) begin
                        state <= WAIT_DONE;
                    end else if (i_tx_done) begin
                        state <= GAP;
                    end else if (tmo_cnt == 2'd3) begin
                        // Transmitter never started: flag it and drop the byte.
                        o_tx_err <= 1'b1;
                        o_busy   <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 2'd1;
                    end
                end
                WAIT_DONE: begin
                    if (i_tx_done) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_CNT_EN
    // Saturating count of writes dropped because the FIFO was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_ovf_cnt <= 8'h00;
        end else if (i_wr_en && o_full && (o_ovf_cnt != 8'hFF)) begin
            o_ovf_cnt <= o_ovf_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, hand-written corner sequences, randomized streaming.
// A queue-based reference model checks byte order, count and flags every cycle.
// Covers o_ovf_cnt when UART_TX_FIFO_OVF_CNT_EN is defined.
module tb_uart_tx_fifo;

    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           wr_en = 1'b0;
    logic [7:0]     wr_byte = 8'h00;
    logic           m_act = 1'b0, m_done = 1'b0;
    logic           r_act, r_done;
    logic           resp_en = 1'b0;
    logic           tx_active, tx_done;
    logic           o_full, o_empty, o_tx_dv, o_busy, o_tx_err;
    logic [DL2:0]   o_count;
    logic [7:0]     o_tx_byte;
`ifdef UART_TX_FIFO_OVF_CNT_EN
    logic [7:0]     o_ovf_cnt;
`endif

    assign tx_active = resp_en ? r_act  : m_act;
    assign tx_done   = resp_en ? r_done : m_done;

    uart_tx_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (wr_en),
        .i_wr_byte  (wr_byte),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_count    (o_count),
        .o_tx_dv    (o_tx_dv),
        .o_tx_byte  (o_tx_byte),
        .i_tx_active(tx_active),
        .i_tx_done  (tx_done),
        .o_busy     (o_busy),
        .o_tx_err   (o_tx_err)
`ifdef UART_TX_FIFO_OVF_CNT_EN
        ,
        .o_ovf_cnt  (o_ovf_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: accepted-but-unsent bytes ----------------
    logic [7:0] q[$];
    int drops_m   = 0;
    int last_done = -100;
    int cyc       = 0;

    initial begin
        logic       s_rst, s_wr, s_done;
        logic [7:0] s_b, exp_b;
        int         sz;
        forever begin
            @(posedge clk);
            s_rst  = rst;
            s_wr   = wr_en;
            s_b    = wr_byte;
            s_done = tx_done;
            sz     = q.size();
            #1;
            cyc++;
            if (s_rst) begin
                q.delete();
                drops_m   = 0;
                last_done = -100;
            end else begin
                if (s_wr) begin
                    if (sz < DEPTH) q.push_back(s_b);
                    else if (drops_m < 255) drops_m++;
                end
                if (s_done) last_done = cyc - 1;
                if (o_tx_dv) begin
                    chk("dv_has_queued_byte", q.size() != 0, 1);
                    chk("dv_gap_after_done", (cyc - last_done) >= 2, 1);
                    if (q.size() != 0) begin
                        exp_b = q.pop_front();
                        chk("tx_order", o_tx_byte, exp_b);
                    end
                end
            end
            chk("model_count", o_count, q.size());
            chk("model_empty", o_empty, q.size() == 0);
            chk("model_full", o_full, q.size() == DEPTH);
            chk("count_le_depth", o_count <= DEPTH, 1);
`ifdef UART_TX_FIFO_OVF_CNT_EN
            chk("model_ovf_cnt", o_ovf_cnt, drops_m);
`endif
        end
    end

    // ---------------- behavioural transmitter ----------------
    initial begin
        int d, l;
        r_act  = 1'b0;
        r_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (resp_en && o_tx_dv) begin
                d = $urandom_range(1, 3);
                repeat (d) @(posedge clk);
                #2 r_act = 1'b1;
                l = $urandom_range(1, 4);
                repeat (l) @(posedge clk);
                #2 begin r_act = 1'b0; r_done = 1'b1; end
                @(posedge clk);
                #2 r_done = 1'b0;
            end
        end
    end

    // Watchdog: the run must always end.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic r, input logic w, input logic [7:0] b,
                        input logic a, input logic d);
        rst = r; wr_en = w; wr_byte = b; m_act = a; m_done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (!(o_empty && !o_busy) && n < 3000) begin
            step(0, 0, 8'h00, 0, 0);
            n++;
        end
        chk(nm, o_empty && !o_busy, 1);
    endtask

    typedef struct {
        logic       rst, wr;
        logic [7:0] b;
        logic       act, done;
        logic       e_dv;
        logic [7:0] e_byte;
        int         e_cnt;
        logic       e_empty, e_full, e_busy, e_err;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(logic r, logic w, logic [7:0] b, logic a, logic d,
                                logic dv, logic [7:0] eb, int c,
                                logic em, logic fu, logic bu, logic er);
        vec_t v;
        v.rst = r; v.wr = w; v.b = b; v.act = a; v.done = d;
        v.e_dv = dv; v.e_byte = eb; v.e_cnt = c;
        v.e_empty = em; v.e_full = fu; v.e_busy = bu; v.e_err = er;
        return v;
    endfunction

    initial begin
        int n;
        // Single frame 0xA5, then a start timeout followed by a normal frame.
        vecs[0]  = mk(1, 0, 8'h00, 0, 0,  0, 8'h00, 0, 1, 0, 0, 0);
        vecs[1]  = mk(0, 1, 8'hA5, 0, 0,  0, 8'h00, 1, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 8'h00, 0, 0,  1, 8'hA5, 0, 1, 0, 1, 0);
        vecs[3]  = mk(0, 0, 8'h00, 0, 0,  0, 8'hA5, 0, 1, 0, 1, 0);
        vecs[4]  = mk(0, 0, 8'h00, 1, 0,  0, 8'hA5, 0, 1, 0, 1, 0);
        vecs[5]  = mk(0, 0, 8'h00, 1, 0,  0, 8'hA5, 0, 1, 0, 1, 0);
        vecs[6]  = mk(0, 0, 8'h00, 0, 1,  0, 8'hA5, 0, 1, 0, 1, 0);
        vecs[7]  = mk(0, 0, 8'h00, 0, 0,  0, 8'hA5, 0, 1, 0, 0, 0);
        vecs[8]  = mk(0, 0, 8'h00, 0, 0,  0, 8'hA5, 0, 1, 0, 0, 0);
        vecs[9]  = mk(0, 1, 8'h3C, 0, 0,  0, 8'hA5, 1, 0, 0, 0, 0);
        vecs[10] = mk(0, 1, 8'h5A, 0, 0,  1, 8'h3C, 1, 0, 0, 1, 0);
        vecs[11] = mk(0, 0, 8'h00, 0, 0,  0, 8'h3C, 1, 0, 0, 1, 0);
        vecs[12] = mk(0, 0, 8'h00, 0, 0,  0, 8'h3C, 1, 0, 0, 1, 0);
        vecs[13] = mk(0, 0, 8'h00, 0, 0,  0, 8'h3C, 1, 0, 0, 1, 0);
        vecs[14] = mk(0, 0, 8'h00, 0, 0,  0, 8'h3C, 1, 0, 0, 1, 0);
        vecs[15] = mk(0, 0, 8'h00, 0, 0,  0, 8'h3C, 1, 0, 0, 0, 1);
        vecs[16] = mk(0, 0, 8'h00, 0, 0,  1, 8'h5A, 0, 1, 0, 1, 0);
        vecs[17] = mk(0, 0, 8'h00, 0, 0,  0, 8'h5A, 0, 1, 0, 1, 0);
        vecs[18] = mk(0, 0, 8'h00, 1, 0,  0, 8'h5A, 0, 1, 0, 1, 0);
        vecs[19] = mk(0, 0, 8'h00, 0, 1,  0, 8'h5A, 0, 1, 0, 1, 0);
        vecs[20] = mk(0, 0, 8'h00, 0, 0,  0, 8'h5A, 0, 1, 0, 0, 0);

        #1;
        for (int i = 0; i < 21; i++) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].b, vecs[i].act, vecs[i].done);
            chk($sformatf("vec%0d_dv", i),    o_tx_dv,   vecs[i].e_dv);
            chk($sformatf("vec%0d_byte", i),  o_tx_byte, vecs[i].e_byte);
            chk($sformatf("vec%0d_count", i), o_count,   vecs[i].e_cnt);
            chk($sformatf("vec%0d_empty", i), o_empty,   vecs[i].e_empty);
            chk($sformatf("vec%0d_full", i),  o_full,    vecs[i].e_full);
            chk($sformatf("vec%0d_busy", i),  o_busy,    vecs[i].e_busy);
            chk($sformatf("vec%0d_err", i),   o_tx_err,  vecs[i].e_err);
        end

        // Burst of 20 writes with the transmitter held busy: 17 accepted, 1 popped, 3 dropped.
        for (int k = 0; k < 20; k++) step(0, 1, 8'(k), 1, 0);
        chk("burst_full", o_full, 1);
        chk("burst_count", o_count, DEPTH);
`ifdef UART_TX_FIFO_OVF_CNT_EN
        chk("burst_ovf", o_ovf_cnt, 3);
`endif
        // Finish the frame, then push while full in the same cycle as a pop.
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 0);
        step(0, 1, 8'hEE, 0, 0);
        chk("full_pop_dv", o_tx_dv, 1);
        chk("full_pop_byte", o_tx_byte, 8'h01);
        chk("full_pop_count", o_count, DEPTH - 1);
        chk("full_pop_full", o_full, 0);
`ifdef UART_TX_FIFO_OVF_CNT_EN
        chk("full_pop_ovf", o_ovf_cnt, 4);
`endif
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 1);
        resp_en = 1'b1;
        drain("burst_drain");
        resp_en = 1'b0;

        // Reset during WAIT_DONE with 5 bytes queued; write in the reset cycle is ignored.
        for (int k = 0; k < 6; k++) step(0, 1, 8'h40 + 8'(k), 1, 0);
        step(0, 0, 8'h00, 1, 0);
        chk("pre_rst_count", o_count, 5);
        chk("pre_rst_busy", o_busy, 1);
        step(1, 1, 8'h77, 1, 0);
        chk("rst_dv", o_tx_dv, 0);
        chk("rst_byte", o_tx_byte, 8'h00);
        chk("rst_count", o_count, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_err", o_tx_err, 0);
`ifdef UART_TX_FIFO_OVF_CNT_EN
        chk("rst_ovf", o_ovf_cnt, 0);
`endif
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 8'h00, 0, k == 2);
            chk("post_rst_no_dv", o_tx_dv, 0);
        end
        step(0, 1, 8'h99, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("recover_dv", o_tx_dv, 1);
        chk("recover_byte", o_tx_byte, 8'h99);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 0);
        chk("recover_idle", o_busy, 0);

        // Random streaming that never overflows: 3 x depth bytes through the pointers.
        resp_en = 1'b1;
        n = 0;
        for (int c = 0; c < 4000 && n < 3 * DEPTH; c++) begin
            if ($urandom_range(0, 1) == 1 && q.size() < DEPTH) begin
                step(0, 1, 8'($urandom), 0, 0);
                n++;
            end else begin
                step(0, 0, 8'h00, 0, 0);
            end
        end
        chk("stream_written", n, 3 * DEPTH);
        drain("stream_drain");

        // Random writes allowed to overflow; model tracks drops.
        for (int c = 0; c < 300; c++) begin
            step(0, $urandom_range(0, 3) != 0, 8'($urandom), 0, 0);
        end
        drain("ovf_drain");
        resp_en = 1'b0;

        step(0, 0, 8'h00, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
